// File: rtl/cmd_engine.sv
// rtl/cmd_engine.sv - byte-stream command engine: RAM write/read, LFSR generate/check, status
// Ports:
//   clk_i, rstn_i                        clock, asynchronous active-low reset
//   out_data_i/out_valid_i/out_ready_o   host-to-device byte stream (commands and payload)
//   in_data_o/in_valid_o/in_ready_i      device-to-host byte stream (read data, LFSR bytes, status)
//   err_o                                high while the LFSR mismatch count is nonzero
module cmd_engine #(
    parameter int                RAM_AW    = 10,
    parameter int                LFSR_W    = 24,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = 24'hE10000,
    parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_W'(1)
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic [7:0] out_data_i,
    input  logic       out_valid_i,
    output logic       out_ready_o,
    output logic [7:0] in_data_o,
    output logic       in_valid_o,
    input  logic       in_ready_i,
    output logic       err_o
);

    localparam int         DEPTH      = 1 << RAM_AW;
    localparam logic [7:0] OP_RAM_WR  = 8'h01;
    localparam logic [7:0] OP_RAM_RD  = 8'h02;
    localparam logic [7:0] OP_LFSR_WR = 8'h03;
    localparam logic [7:0] OP_GEN     = 8'h04;
    localparam logic [7:0] OP_CHK     = 8'h05;
    localparam logic [7:0] OP_STAT    = 8'h06;

    typedef enum logic [2:0] {
        S_IDLE, S_ARG, S_RAM_WR, S_RAM_RD, S_GEN, S_CHK, S_STAT
    } state_t;

    state_t              r_state;
    logic [7:0]          r_op;
    logic [15:0]         r_arg_lo;
    logic [1:0]          r_argcnt;
    logic [23:0]         r_rem;      // bytes left after the current one (LEN-1 at start)
    logic                r_done;     // output states: last byte already loaded
    logic [RAM_AW-1:0]   r_addr;
    logic [LFSR_W-1:0]   r_lfsr;
    logic [15:0]         r_err;
    logic                r_out_ready;
    logic                r_in_valid;
    logic [7:0]          r_in_data;
    logic [7:0]          r_mem [0:DEPTH-1];

    logic                w_out_fire;
    logic                w_in_fire;
    logic                w_can_load;
    logic [23:0]         w_arg;
    logic [31:0]         w_arg32;
    logic [LFSR_W-1:0]   w_seed_arg;
    logic [LFSR_W-1:0]   w_lfsr_next;
    logic                w_mismatch;
    logic [7:0]          w_src;

    assign w_out_fire  = out_valid_i & r_out_ready;
    assign w_in_fire   = r_in_valid & in_ready_i;
    // Output register may take a new byte when empty or when its byte leaves this cycle.
    assign w_can_load  = (!r_in_valid || in_ready_i) && !r_done;
    assign w_arg       = {out_data_i, r_arg_lo};
    assign w_arg32     = {8'd0, w_arg};
    assign w_seed_arg  = w_arg32[LFSR_W-1:0];
    assign w_lfsr_next = (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_TAPS : '0);
    assign w_mismatch  = (out_data_i != r_lfsr[7:0]);

    always_comb begin
        w_src = 8'd0;
        case (r_state)
            S_RAM_RD: w_src = r_mem[r_addr];
            S_GEN:    w_src = r_lfsr[7:0];
            // STAT starts with r_rem=1: low byte first, then high byte.
            S_STAT:   w_src = r_rem[0] ? r_err[7:0] : r_err[15:8];
            default:  w_src = 8'd0;
        endcase
    end

    // RAM has no reset so its contents survive a reset.
    always_ff @(posedge clk_i) begin
        if (r_state == S_RAM_WR && w_out_fire) begin
            r_mem[r_addr] <= out_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state     <= S_IDLE;
            r_op        <= 8'd0;
            r_arg_lo    <= 16'd0;
            r_argcnt    <= 2'd0;
            r_rem       <= 24'd0;
            r_done      <= 1'b0;
            r_addr      <= '0;
            r_lfsr      <= LFSR_SEED;
            r_err       <= 16'd0;
            r_out_ready <= 1'b0;
            r_in_valid  <= 1'b0;
            r_in_data   <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_out_ready <= 1'b1;
                    if (w_out_fire) begin
                        r_op     <= out_data_i;
                        r_argcnt <= 2'd0;
                        r_state  <= S_ARG;
                    end
                end
                S_ARG: begin
                    if (w_out_fire) begin
                        if (r_argcnt == 2'd0) begin
                            r_arg_lo[7:0] <= out_data_i;
                            r_argcnt      <= 2'd1;
                        end else if (r_argcnt == 2'd1) begin
                            r_arg_lo[15:8] <= out_data_i;
                            r_argcnt       <= 2'd2;
                        end else begin
                            r_rem  <= w_arg;
                            r_addr <= '0;
                            r_done <= 1'b0;
                            case (r_op)
                                OP_RAM_WR: r_state <= S_RAM_WR;
                                OP_RAM_RD: begin
                                    r_state     <= S_RAM_RD;
                                    r_out_ready <= 1'b0;
                                end
                                OP_LFSR_WR: begin
                                    r_lfsr  <= (w_seed_arg == '0) ? LFSR_W'(1) : w_seed_arg;
                                    r_state <= S_IDLE;
                                end
                                OP_GEN: begin
                                    r_state     <= S_GEN;
                                    r_out_ready <= 1'b0;
                                end
                                OP_CHK:  r_state <= S_CHK;
                                OP_STAT: begin
                                    r_rem       <= 24'd1;
                                    r_state     <= S_STAT;
                                    r_out_ready <= 1'b0;
                                end
                                default: r_state <= S_IDLE;
                            endcase
                        end
                    end
                end
                S_RAM_WR, S_CHK: begin
                    if (w_out_fire) begin
                        if (r_state == S_RAM_WR) begin
                            r_addr <= r_addr + RAM_AW'(1);
                        end else begin
                            r_lfsr <= w_lfsr_next;
                            if (w_mismatch && r_err != 16'hFFFF) begin
                                r_err <= r_err + 16'd1;
                            end
                        end
                        if (r_rem == 24'd0) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_rem <= r_rem - 24'd1;
                        end
                    end
                end
                S_RAM_RD, S_GEN, S_STAT: begin
                    if (w_can_load) begin
                        r_in_valid <= 1'b1;
                        r_in_data  <= w_src;
                        if (r_state == S_RAM_RD) r_addr <= r_addr + RAM_AW'(1);
                        if (r_state == S_GEN)    r_lfsr <= w_lfsr_next;
                        if (r_rem == 24'd0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_rem <= r_rem - 24'd1;
                        end
                    end else if (w_in_fire) begin
                        // Only reached with r_done set: the final byte just left.
                        r_in_valid  <= 1'b0;
                        r_out_ready <= 1'b1;
                        r_state     <= S_IDLE;
                        if (r_state == S_STAT) r_err <= 16'd0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out_ready_o = r_out_ready;
    assign in_valid_o  = r_in_valid;
    assign in_data_o   = r_in_data;
    assign err_o       = (r_err != 16'd0);

endmodule

// File: doc/cmd_engine.md
CMD_ENGINE -- requirements
Module: cmd_engine

Interface
REQ-001 SHALL have parameter RAM_AW, default 10, meaning RAM address width (2^RAM_AW bytes).
REQ-002 SHALL have parameter LFSR_W, default 24, range 8..32, meaning LFSR register width.
REQ-003 SHALL have parameter LFSR_TAPS, default 24'hE10000, meaning Galois feedback mask (LFSR_W bits).
REQ-004 SHALL have parameter LFSR_SEED, default 1, meaning LFSR reset value.
REQ-005 SHALL have ports clk_i in 1 (sole clock) and rstn_i in 1 (reset, asynchronous, active-low).
REQ-006 SHALL have ports out_data_i in 8, out_valid_i in 1, out_ready_o out 1 (host-to-device byte stream).
REQ-007 SHALL have ports in_data_o out 8, in_valid_o out 1, in_ready_i in 1 (device-to-host byte stream).
REQ-008 SHALL have port err_o out 1, high while error count is nonzero.

Function
REQ-009 SHALL transfer a byte on either stream only in a cycle where valid and ready are both high; in_data_o/in_valid_o held stable while in_valid_o=1 and in_ready_i=0.
REQ-010 SHALL parse each command as an opcode byte plus 3 argument bytes, little-endian, into ARG[23:0]; LEN = ARG+1 (1..2^24).
REQ-011 SHALL implement states IDLE, ARG, RAM_WR, RAM_RD, GEN, CHK, STAT; IDLE->ARG on any accepted byte, ARG->command state after third argument byte.
REQ-012 SHALL treat an unknown opcode as: consume 3 argument bytes, no action, return to IDLE.
REQ-013 SHALL for 0x01 RAM_WRITE accept LEN bytes into RAM at addresses 0,1,2,... with address wrapping modulo 2^RAM_AW.
REQ-014 SHALL for 0x02 RAM_READ emit LEN bytes from RAM addresses 0,1,2,... wrapping modulo 2^RAM_AW; sustain one byte per cycle when in_ready_i stays high; first byte valid no later than 2 cycles after the last argument byte is accepted.
REQ-015 SHALL for 0x03 LFSR_WRITE load LFSR with ARG[LFSR_W-1:0] (zero-extended when LFSR_W>24) in the cycle after the last argument byte; a zero value loads 1.
REQ-016 SHALL for 0x04 LFSR_IN emit LEN bytes, each equal to LFSR[7:0], advancing LFSR one step per emitted byte.
REQ-017 SHALL define one LFSR step as: next = (L>>1) ^ (L[0] ? LFSR_TAPS : 0).
REQ-018 SHALL for 0x05 LFSR_OUT accept LEN bytes, compare each with LFSR[7:0], advance one step per byte, and increment a 16-bit error count per mismatch, saturating at 16'hFFFF.
REQ-019 SHALL for 0x06 STATUS emit 2 bytes, error count low then high, then clear the count; a mismatch in that clear cycle is lost.
REQ-020 SHALL keep out_ready_o=0 in RAM_RD, GEN and STAT, and out_ready_o=1 in IDLE, ARG, RAM_WR and CHK.
REQ-021 SHALL return to IDLE after the last byte of a command transfers, ready to accept an opcode the next cycle.
REQ-022 SHALL hold in_valid_o=0 in every state other than RAM_RD, GEN and STAT.

Reset
REQ-023 SHALL on rstn_i low immediately force IDLE, in_valid_o=0, out_ready_o=0, LFSR=LFSR_SEED, error count=0, err_o=0, counters=0; out_ready_o=1 from the first clock edge after release.
REQ-024 SHALL abort any command in progress on reset; RAM contents are not reset and remain readable afterwards.

Verification
REQ-025 Write 01 06 00 00 then 01..07, then 02 06 00 00 -> in stream 01 02 03 04 05 06 07 exactly, then IDLE.
REQ-026 Write 03 81 38 33, then 04 09 00 00 -> 10 bytes matching the REQ-017 model seeded 24'h333881; a second 04 continues the sequence.
REQ-027 Seed 24'h333881, 05 09 00 00 with model bytes except byte 4 inverted -> err_o=1; 06 00 00 00 -> 01 00; then 06 again -> 00 00, err_o=0.
REQ-028 RAM_AW=4, RAM_WRITE LEN=20 of bytes 0..19 -> RAM_READ LEN=16 returns 10 11 12 13 04 05 ... 0F (wrap overwrite).
REQ-029 RAM_READ LEN=55 with in_ready_i random 50% -> no byte lost or duplicated; in_data_o stable while stalled.
REQ-030 Assert rstn_i mid LFSR_IN -> in_valid_o=0 at once; after release 04 00 00 00 returns LFSR_SEED[7:0].
